// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver.
//   - uart_state_t : frame state encoding (IDLE, START, DATA, PARITY, STOP)
//   - UART_CLKS_PER_BIT_DEFAULT : 50 MHz system clock / 9600 baud
//   - UART_DATA_BITS : data bits per frame
//   - even_parity() : parity bit for a data byte (XOR of all data bits)
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_CLKS_PER_BIT_DEFAULT = 5208;
  localparam int UART_DATA_BITS            = 8;
  localparam int UART_BIT_IDX_W            = $clog2(UART_DATA_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// ---------------------------------------------------------------------------
// uart_baud_cnt
// Restartable bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps; bit_end
// marks the last cycle of each bit period. Holding restart high parks the
// counter at 0 so the next period starts cleanly when restart drops.
// Shared by the transmitter and the receiver.
//
// Parameters
//   CLKS_PER_BIT : system clock cycles per serial bit (minimum 2)
// Ports
//   sysclk  in  system clock, rising-edge active
//   reset   in  asynchronous active-high reset (counter to 0)
//   restart in  force the counter back to 0 on the next edge
//   bit_end out high on the final cycle of the current bit period
// ---------------------------------------------------------------------------
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic sysclk,
  input  logic reset,
  input  logic restart,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = (cnt == CNT_MAX);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmitter: 8 data bits, LSB first, one stop bit, idle-high line.
// A one-deep holding register decouples the CPU write from the shifter, so
// a byte written during a frame is sent immediately after it with no idle
// gap between the stop bit and the next start bit.
//
// Optional feature (compile-time macro):
//   UART_TX_PARITY_EN : insert an even-parity bit between the last data bit
//                       and the stop bit (8E1, 11 bit periods per frame).
//                       Undefined: 8N1, no parity state or logic.
//
// Parameters
//   CLKS_PER_BIT : system clock cycles per serial bit (minimum 2)
// Ports
//   sysclk   in   system clock, rising-edge active
//   reset    in   asynchronous active-high reset
//   tx_data  in   byte to send, sampled on an accepted tx_start
//   tx_start in   write strobe, accepted when tx_ready is high
//   tx_ready out  holding register empty
//   tx_busy  out  a frame is in progress (state is not IDLE)
//   tx_done  out  one-cycle pulse on the last cycle of each stop bit
//   UART_TX  out  serial line
//
// The serial line and tx_done are registered one cycle behind the state
// machine so the pin is glitch-free: state enters START one edge after the
// byte is accepted, and the line falls on the following edge.
// ---------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       UART_TX
);

  localparam logic [UART_BIT_IDX_W-1:0] LAST_BIT = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

  uart_state_t state, state_nxt;

  logic [UART_DATA_BITS-1:0] hold_q;
  logic                      hold_full;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_BIT_IDX_W-1:0] bit_idx;
  logic                      bit_end;
  logic                      accept;
  logic                      load_shift;
  logic                      line_nxt;
  logic                      line_p1;
  logic                      done_p1;

`ifdef UART_TX_PARITY_EN
  logic                      parity_q;
`endif

  // A write is only taken while the holding register is empty; a write that
  // coincides with a holding-to-shift transfer sees tx_ready=0 and is dropped.
  assign accept   = tx_start && !hold_full;
  assign tx_ready = !hold_full;
  assign tx_busy  = (state != IDLE);
  assign tx_done  = done_p1;
  assign UART_TX  = line_p1;

  // The bit timer is parked at zero while idle, so the start bit always gets
  // a full period. Between frames it simply wraps at the stop-bit end.
  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_cnt (
    .sysclk  (sysclk),
    .reset   (reset),
    .restart (state == IDLE),
    .bit_end (bit_end)
  );

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    load_shift = 1'b0;
    line_nxt   = 1'b1;
    case (state)
      IDLE: begin
        if (hold_full) begin
          load_shift = 1'b1;
          state_nxt  = START;
        end
      end
      START: begin
        line_nxt = 1'b0;
        if (bit_end) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        line_nxt = shift_q[0];
        if (bit_end && (bit_idx == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line_nxt = parity_q;
        if (bit_end) begin
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        line_nxt = 1'b1;
        if (bit_end) begin
          // A byte already waiting goes straight out: stop bit is followed
          // directly by the next start bit.
          if (hold_full) begin
            load_shift = 1'b1;
            state_nxt  = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage p0: holding register and shifter.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
      shift_q   <= '0;
      bit_idx   <= '0;
    end else begin
      if (load_shift) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_q    <= tx_data;
        hold_full <= 1'b1;
      end

      if (load_shift) begin
        shift_q <= hold_q;
        bit_idx <= '0;
      end else if ((state == DATA) && bit_end) begin
        shift_q <= shift_q >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is fixed when the byte enters the shifter, since the shift
  // register no longer holds the full byte by the time the parity bit is sent.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (load_shift) begin
      parity_q <= even_parity(hold_q);
    end
  end
`endif

  // Stage p1: registered line and done pulse, aligned with each other.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      line_p1 <= 1'b1;
      done_p1 <= 1'b0;
    end else begin
      line_p1 <= line_nxt;
      done_p1 <= (state == STOP) && bit_end;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB     = 16;
  localparam int CPB_DEF = 5208;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       sysclk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready, tx_busy, tx_done, uart_line;

  logic       reset_def;
  logic [7:0] tx_data_def;
  logic       tx_start_def;
  logic       tx_ready_def, tx_busy_def, tx_done_def, uart_line_def;

  int n_checks = 0;
  int n_errors = 0;

  always #10 sysclk = ~sysclk;

  uart_tx #(.CLKS_PER_BIT(CPB)) u_dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .UART_TX  (uart_line)
  );

  uart_tx u_dut_def (
    .sysclk   (sysclk),
    .reset    (reset_def),
    .tx_data  (tx_data_def),
    .tx_start (tx_start_def),
    .tx_ready (tx_ready_def),
    .tx_busy  (tx_busy_def),
    .tx_done  (tx_done_def),
    .UART_TX  (uart_line_def)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Line bits of one frame, index 0 = start bit.
  function automatic logic [FRAME_BITS-1:0] frame_bits(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge sysclk);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge sysclk);
    tx_start = 1'b0;
  endtask

  // Called at the negedge just after the accepting edge.
  task automatic wait_fall(input string tag);
    int k = 0;
    while (uart_line !== 1'b0 && k < 4 * CPB) begin
      @(negedge sysclk);
      k++;
    end
    check_val(tag, k, 2);
  endtask

  // Starts at the first negedge of a start bit; checks every cycle of each bit
  // and the position of every tx_done pulse.
  task automatic check_frames(input string tag, input logic [63:0] bits, input int nframes);
    int             done_pos[$];
    logic [CPB-1:0] samp;
    logic           busy_mid = 1'b0;
    for (int b = 0; b < nframes * FRAME_BITS; b++) begin
      for (int c = 0; c < CPB; c++) begin
        samp[c] = uart_line;
        if (tx_done === 1'b1) done_pos.push_back(b * CPB + c);
        if (b == 0 && c == CPB / 2) busy_mid = tx_busy;
        @(negedge sysclk);
      end
      check_val($sformatf("%s_bit%0d", tag, b), samp, {CPB{bits[b]}});
    end
    check_val({tag, "_busy"}, busy_mid, 1'b1);
    check_val({tag, "_done_cnt"}, done_pos.size(), nframes);
    for (int f = 0; f < nframes; f++) begin
      check_val($sformatf("%s_done_pos%0d", tag, f),
                (f < done_pos.size()) ? done_pos[f] : -1,
                (f + 1) * FRAME_BITS * CPB - 1);
    end
  endtask

  task automatic check_idle(input string tag, input int cycles);
    int bad = 0;
    repeat (cycles) begin
      if (uart_line !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
      @(negedge sysclk);
    end
    check_val(tag, bad, 0);
  endtask

  task automatic wait_def(input logic val, output realtime t);
    int k = 0;
    while (uart_line_def !== val && k < 3 * CPB_DEF) begin
      @(negedge sysclk);
      k++;
    end
    t = $realtime;
  endtask

  initial begin
    realtime t0, t1, t2, t3, t4, t5;
    int k;

    reset = 1'b1; tx_start = 1'b0; tx_data = 8'h00;
    reset_def = 1'b1; tx_start_def = 1'b0; tx_data_def = 8'h00;
    repeat (3) @(negedge sysclk);
    check_val("rst_line", uart_line, 1'b1);
    check_val("rst_ready", tx_ready, 1'b1);
    check_val("rst_busy", tx_busy, 1'b0);
    check_val("rst_done", tx_done, 1'b0);
    reset = 1'b0;
    check_idle("rst_idle", 5);

    // Single frame 0x55.
    send(8'h55);
    check_val("f55_ready_low", tx_ready, 1'b0);
    wait_fall("f55_latency");
    check_frames("f55", 64'(frame_bits(8'h55)), 1);
    check_val("f55_ready_after", tx_ready, 1'b1);
    check_idle("f55_idle", 2 * CPB);

    // Back-to-back: second byte written while the first is shifting.
    send(8'hA3);
    wait_fall("b2b_latency");
    fork
      check_frames("b2b", 64'({frame_bits(8'h0F), frame_bits(8'hA3)}), 2);
      begin
        repeat (20) @(negedge sysclk);
        check_val("b2b_ready_mid", tx_ready, 1'b1);
        send(8'h0F);
      end
    join
    check_idle("b2b_idle", 2 * CPB);

    // Three writes during one frame: the third is ignored.
    send(8'h3C);
    wait_fall("w3_latency");
    fork
      check_frames("w3", 64'({frame_bits(8'hC5), frame_bits(8'h3C)}), 2);
      begin
        repeat (20) @(negedge sysclk);
        send(8'hC5);
        repeat (10) @(negedge sysclk);
        check_val("w3_ready_full", tx_ready, 1'b0);
        send(8'hFF);
      end
    join
    check_idle("w3_idle", 2 * FRAME_BITS * CPB);

    // Write on the same edge as the holding-to-shift transfer is dropped.
    send(8'hC3);
    tx_data  = 8'h99;
    tx_start = 1'b1;
    @(negedge sysclk);
    tx_start = 1'b0;
    k = 0;
    while (uart_line !== 1'b0 && k < 4 * CPB) begin
      @(negedge sysclk);
      k++;
    end
    check_val("sim_latency", k, 1);
    check_frames("sim", 64'(frame_bits(8'hC3)), 1);
    check_idle("sim_idle", 2 * FRAME_BITS * CPB);

    // Parity-sensitive bytes (parity bit present only with the macro).
    send(8'h07);
    wait_fall("p07_latency");
    check_frames("p07", 64'(frame_bits(8'h07)), 1);
    send(8'h03);
    wait_fall("p03_latency");
    check_frames("p03", 64'(frame_bits(8'h03)), 1);
    check_idle("p_idle", CPB);

    // Reset in the middle of the data bits of 0x00.
    send(8'h00);
    wait_fall("rmid_latency");
    repeat (CPB + 40) @(negedge sysclk);
    check_val("rmid_busy_before", tx_busy, 1'b1);
    check_val("rmid_line_before", uart_line, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_val("rmid_line", uart_line, 1'b1);
    check_val("rmid_busy", tx_busy, 1'b0);
    check_val("rmid_ready", tx_ready, 1'b1);
    @(negedge sysclk);
    reset = 1'b0;
    check_idle("rmid_after", 12 * CPB);

    // Default bit period on the second instance, 0xA5 = bits 1,0,1,0,0,1,0,1.
    reset_def = 1'b0;
    @(negedge sysclk);
    tx_data_def  = 8'hA5;
    tx_start_def = 1'b1;
    @(negedge sysclk);
    tx_start_def = 1'b0;
    wait_def(1'b0, t0);
    wait_def(1'b1, t1);
    wait_def(1'b0, t2);
    wait_def(1'b1, t3);
    wait_def(1'b0, t4);
    wait_def(1'b1, t5);
    check_val("def_start_ns", 32'(longint'(t1 - t0)), 32'd104160);
    check_val("def_bit0_ns", 32'(longint'(t2 - t1)), 32'd104160);
    check_val("def_bit1_ns", 32'(longint'(t3 - t2)), 32'd104160);
    check_val("def_bit2_ns", 32'(longint'(t4 - t3)), 32'd104160);
    check_val("def_bit34_ns", 32'(longint'(t5 - t4)), 32'd208320);
    reset_def = 1'b1;
    @(negedge sysclk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the transmit-side counterpart to the CPU's UART receiver. It accepts bytes from the CPU peripheral bus through a one-deep holding register and shifts them out on `UART_TX` as 8N1 frames, LSB first, at the configured baud rate. It sits in the CPU's peripheral block next to the receiver and drives the board's TX pin directly.

## Interface
- `CLKS_PER_BIT`, default 5208: sysclk cycles per serial bit (50 MHz / 9600 baud); legal minimum 2.
- `sysclk`  in  1  system clock, rising-edge active.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_data`  in  8  byte to send; sampled only on an accepted `tx_start`.
- `tx_start`  in  1  write strobe; accepted on a rising edge where `tx_ready`=1.
- `tx_ready`  out  1  holding register is empty and can accept a byte.
- `tx_busy`  out  1  a frame is on the line (state ≠ IDLE).
- `tx_done`  out  1  one-cycle pulse on the last cycle of each stop bit.
- `UART_TX`  out  1  serial line; idles high.

## Operation
- Reset values (asynchronous, immediate): `UART_TX`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0. Reset also clears the holding register, shift register, bit index and baud counter.
- Holding register:
  - An accepted `tx_start` loads `tx_data` and clears `tx_ready` on the same edge.
  - `tx_start` while `tx_ready`=0 is ignored; the held byte is not overwritten.
- State machine: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
  - IDLE: `UART_TX`=1. When the holding register is full, move it to the shift register, set `tx_ready`=1 and go to START.
  - START: `UART_TX`=0 for CLKS_PER_BIT cycles.
  - DATA: `UART_TX`=shift[0]. Shift right every CLKS_PER_BIT cycles. Bit index counts 0..7; leave after bit 7.
  - PARITY: present only with the macro (see Configuration).
  - STOP: `UART_TX`=1 for CLKS_PER_BIT cycles. `tx_done` is high on the final cycle.
    - If the holding register is full on that final cycle, load it and enter START directly, so there is no idle gap between frames.
    - Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and restarts from 0 on every bit transition. Its width is clog2(CLKS_PER_BIT).
- A byte accepted during a frame waits in the holding register. This allows continuous streaming at full line rate.

## Timing
- Latency: if `tx_start` is accepted while IDLE with an empty pipeline, `UART_TX` falls 2 cycles after the accepting edge (1 cycle to load the holding register, 1 cycle to transfer).
- Every bit lasts exactly CLKS_PER_BIT cycles. Frame length is 10×CLKS_PER_BIT cycles (52080 at default).
- `tx_ready` returns to 1 one cycle after the holding register is moved into the shift register. In that same cycle a new `tx_start` may be accepted.
- Simultaneous `tx_start` and holding-to-shift transfer on the same edge: the transfer wins. `tx_ready` was 0, so the start is ignored.
- Reset during a frame: the line returns to 1 asynchronously and the partial frame is abandoned. After reset is released, nothing is sent until a new `tx_start`.
- `tx_busy` goes high on the cycle START is entered. It goes low on the first IDLE cycle.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - Adds a PARITY state between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - The parity bit is even parity: the XOR of the 8 data bits.
  - Frame length becomes 11×CLKS_PER_BIT cycles.
- Not defined: 8N1 only; the PARITY state and parity logic are absent.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP);
  - `UART_CLKS_PER_BIT_DEFAULT` = 5208;
  - `UART_DATA_BITS` = 8.
- The same package is to be used by the receiver.
- One natural sub-module, `uart_baud_cnt`: a restartable bit-period counter with a `restart` input and a `bit_end` output. It is reusable by the receiver.

## Test plan
All scenarios use CLKS_PER_BIT=16 unless noted.
- Send 0x55 after reset → `UART_TX` reads 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles. `tx_done` pulses once, at cycle 160 of the frame.
- Default CLKS_PER_BIT, send 0xA5 → each bit lasts 104160 ns at a 20 ns clock.
- Back-to-back 0xA3 then 0x0F, with the second written while the first is shifting → the frames are contiguous (stop bit immediately followed by start bit). `tx_done` pulses twice, 160 cycles apart.
- Three writes during one frame (`tx_start` while `tx_ready`=0) → the third byte is ignored. Only the first two bytes appear on the line.
- Assert `reset` mid-DATA of 0x00 → `UART_TX`=1 immediately, `tx_busy`=0, `tx_ready`=1. No residual bits appear after release.
- With `UART_TX_PARITY_EN`, send 0x07 → the parity bit is 1 and the frame lasts 176 cycles. Send 0x03 → the parity bit is 0.
